mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-stage load/store unit sitting directly downstream of the execute→memory pipeline register. It consumes the memory-stage control and data (`memreadM`, `memwriteM`, `memctrlM`, `aluresultM`, `writedataM`), performs byte, halfword and word accesses against a word-addressed data memory using a request/ready handshake, and returns sign- or zero-extended load data. While a memory transaction is outstanding it stalls the pipeline.

## Interface
- `WIDTH`, 32: data and address width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `memreadM`  in  1  load in memory stage.
- `memwriteM`  in  1  store in memory stage; has priority if both are high.
- `memctrlM`  in  3  funct3 access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU and HU are loads only).
- `aluresultM`  in  WIDTH  byte address.
- `writedataM`  in  WIDTH  store data, right-aligned.
- `readdataM`  out  WIDTH  extended load data.
- `stallM`  out  1  freeze the pipeline, including this stage's inputs.
- `errM`  out  1  misaligned or illegal access; no memory request is issued.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  write request.
- `mem_addr`  out  WIDTH  word-aligned address: `{aluresultM[WIDTH-1:2], 2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  WIDTH  lane-replicated store data.
- `mem_rdata`  in  WIDTH  read word; valid when `mem_ready` is high.
- `mem_ready`  in  1  completes the outstanding request.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `acc = (memreadM|memwriteM) & ~errM`, register `mem_req`=1, `mem_we`=`memwriteM`, `mem_addr`, `mem_be`, `mem_wdata`, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Hold all `mem_*` outputs stable.
  - On `mem_ready`: drop `mem_req`, capture the extended load data into `readdataM` (loads only), and go to DONE.
- DONE: unconditionally return to IDLE.
  - The pipeline advances at the end of this cycle, so the same instruction is never reissued.
- `stallM` (combinational) = `(IDLE & acc) | BUSY`. It is 0 in DONE.
- `errM` (combinational, gated by `memreadM|memwriteM`) is high for:
  - H/HU with `addr[0]=1`;
  - W with `addr[1:0]≠0`;
  - codes 011, 110, 111;
  - stores with BU or HU codes.
- On an `errM` access: no stall, no request, `readdataM` is not updated.
- Byte enables:
  - B: `0001<<addr[1:0]`.
  - H: `0011<<{addr[1],1'b0}`.
  - W: `1111`.
- Store data:
  - B: `{4{wd[7:0]}}`.
  - H: `{2{wd[15:0]}}`.
  - W: `wd`.
- Load extraction:
  - Byte lane is `addr[1:0]`; half lane is `addr[1]`.
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
- The lane select uses `aluresultM`, which is held stable by `stallM` through DONE.
- `mem_ready` outside BUSY is ignored.
- `readdataM` holds its last captured value until the next load completes.

## Timing
- Reset (async, `rst`=0) forces:
  - state to IDLE;
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` to 0;
  - `readdataM` to 0.
  - `stallM` and `errM` then follow their combinational equations, so they are 0 unless an access is presented.
- Reset mid-BUSY drops `mem_req` immediately. A `mem_ready` arriving after reset is ignored.
- Latency: an access presented in cycle 0 has `mem_req` high from cycle 1.
  - With `mem_ready` in cycle 1, DONE occurs in cycle 2 and `readdataM` is valid in cycle 2.
  - Minimum is 3 cycles per access; each wait cycle adds 1.
- `stallM` is high in cycles 0..k, where k is the `mem_ready` cycle, and low in DONE.
- Back-to-back accesses: the next access is seen in the cycle after DONE. There is a 1-cycle IDLE turnaround, with no bubble beyond that.
- Non-memory instructions pass with zero stall.

## Test plan
- LW at `addr`=0x100 with `mem_rdata`=0xDEADBEEF and `mem_ready` one cycle after `mem_req` → `mem_be`=1111, `mem_addr`=0x100, `stallM` high for 2 cycles, `readdataM`=0xDEADBEEF in DONE.
- LB at 0x103 and LBU at 0x103 with word 0x80FF_0102 → `readdataM`=0xFFFFFF80 and 0x00000080 respectively; LH at 0x102 → 0xFFFF80FF.
- SB at 0x101 with `writedataM`=0x12345678 → `mem_we`=1, `mem_be`=0010, `mem_wdata`=0x78787878; SH at 0x102 → `mem_be`=1100, `mem_wdata`=0x56785678.
- LW at 0x102, SH at 0x101, and code 011 → `errM`=1, `mem_req` never asserted, `stallM`=0, `readdataM` unchanged.
- LW with `mem_ready` delayed 5 cycles, and a spurious `mem_ready` while IDLE → `mem_*` stable throughout BUSY, `stallM` high for 6 cycles, spurious ready ignored.
- Assert `rst` low during BUSY → `mem_req`=0 and state IDLE immediately; after release, a fresh LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bundle between the memory-stage LSU
// and a word-addressed data memory.
interface mem_stage_lsu_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: byte/half/word accesses over a
// req/ready word bus, with load extension and pipeline stall.
module mem_stage_lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memreadM,
  input  logic             memwriteM,
  input  logic [2:0]       memctrlM,
  input  logic [WIDTH-1:0] aluresultM,
  input  logic [WIDTH-1:0] writedataM,
  output logic [WIDTH-1:0] readdataM,
  output logic             stallM,
  output logic             errM,
  mem_stage_lsu_if.master  mem
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             rw;
  logic             bad;
  logic             acc;
  logic [1:0]       lane;
  logic [3:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic [WIDTH-1:0] ext_c;

  assign rw   = memreadM | memwriteM;
  assign lane = aluresultM[1:0];

  always_comb begin
    bad = 1'b0;
    unique case (memctrlM)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lane[0];
      3'b010:  bad = |lane;
      3'b100:  bad = memwriteM;
      3'b101:  bad = memwriteM | lane[0];
      default: bad = 1'b1;
    endcase
  end

  assign errM = rw & bad;
  assign acc  = rw & ~bad;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = writedataM;
    unique case (memctrlM[1:0])
      2'b00: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {(WIDTH/8){writedataM[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {lane[1], 1'b0};
        wdata_c = {(WIDTH/16){writedataM[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = writedataM;
      end
    endcase
  end

  // Lane select relies on aluresultM being frozen by stallM.
  assign rbyte = mem.mem_rdata[{lane, 3'b000} +: 8];
  assign rhalf = mem.mem_rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    ext_c = mem.mem_rdata;
    unique case (memctrlM)
      3'b000:  ext_c = {{(WIDTH-8){rbyte[7]}}, rbyte};
      3'b001:  ext_c = {{(WIDTH-16){rhalf[15]}}, rhalf};
      3'b100:  ext_c = {{(WIDTH-8){1'b0}}, rbyte};
      3'b101:  ext_c = {{(WIDTH-16){1'b0}}, rhalf};
      default: ext_c = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          req_d   = 1'b1;
          we_d    = memwriteM;
          addr_d  = {aluresultM[WIDTH-1:2], 2'b00};
          be_d    = be_c;
          wdata_d = wdata_c;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem.mem_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = ext_c;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign stallM = ((state_q == IDLE) & acc) | (state_q == BUSY);

  assign readdataM     = rdata_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule
